// File: rtl/react_stim_ctrl_pkg.sv
// Shared types and constants for the reaction-game stimulus controller.
`timescale 1ns/1ps
package react_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELAY = 3'd1,
        ST_LIT   = 3'd2,
        ST_DONE  = 3'd3,
        ST_FOUL  = 3'd4,
        ST_TOUT  = 3'd5
    } state_e;

    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam int          DEF_CLK_DIV = 50000;
    localparam int          MS_W        = 14;

    // Galois step for x^16+x^14+x^13+x^11+1 (right-shifting form).
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/react_stim_ctrl_if.sv
// Player-facing signals of the stimulus controller: raw buttons in, LED/flags out.
`timescale 1ns/1ps
interface react_stim_if;
    logic       start_raw;
    logic       btn_raw;
    logic       led;
    logic       btn_db;
    logic       false_start;
    logic       timeout;
    logic       busy;
    logic [2:0] state;

    modport master (
        output start_raw, btn_raw,
        input  led, btn_db, false_start, timeout, busy, state
    );

    modport slave (
        input  start_raw, btn_raw,
        output led, btn_db, false_start, timeout, busy, state
    );
endinterface

// File: rtl/react_stim_ctrl_debounce.sv
// 2-FF synchroniser plus ms-tick stability counter; also emits a rising-edge pulse.
`timescale 1ns/1ps
module debounce #(
    parameter int DEB_MS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic ms_tick,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = (DEB_MS > 1) ? $clog2(DEB_MS + 1) : 1;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          rise_q,  rise_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = cnt_q;
        if (ms_tick) begin
            if (sync2_q != level_q) begin
                if (cnt_q == CW'(DEB_MS - 1)) begin
                    level_d = sync2_q;
                    rise_d  = sync2_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    // rise is registered alongside level so both change on the same edge.
    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/react_stim_ctrl.sv
// Reaction-game round controller: ms tick, free-running LFSR delay, LED stimulus FSM.
`timescale 1ns/1ps
module react_stim_ctrl
    import react_pkg::*;
#(
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int TIMEOUT_MS   = 9999,
    parameter int DEB_MS       = 20
) (
    input  logic         clk,
    input  logic         rst,
    react_stim_if.slave  io
);
    localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if ((MIN_DELAY_MS + (2 ** RAND_BITS) - 1) >= (2 ** MS_W) || MIN_DELAY_MS < 1)
    begin : g_param_check
        $error("react_stim_ctrl: MIN_DELAY_MS/RAND_BITS do not fit the 14-bit delay counter");
    end

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              ms_tick;
    logic [15:0]       lfsr_q, lfsr_d;

    state_e            state_q, state_d;
    logic              led_q, led_d;
    logic              false_start_q, false_start_d;
    logic              timeout_q, timeout_d;
    logic              busy_q, busy_d;
    logic [MS_W-1:0]   dly_ms_q, dly_ms_d;
    logic [MS_W-1:0]   on_ms_q, on_ms_d;

    logic              start_rise;
    logic              start_level_unused;
    logic              btn_db;
    logic              btn_rise_unused;

    debounce #(.DEB_MS(DEB_MS)) u_db_start (
        .clk     (clk),
        .rst     (rst),
        .ms_tick (ms_tick),
        .raw     (io.start_raw),
        .level   (start_level_unused),
        .rise    (start_rise)
    );

    debounce #(.DEB_MS(DEB_MS)) u_db_btn (
        .clk     (clk),
        .rst     (rst),
        .ms_tick (ms_tick),
        .raw     (io.btn_raw),
        .level   (btn_db),
        .rise    (btn_rise_unused)
    );

    assign ms_tick = (tick_cnt_q == TICK_W'(CLK_DIV - 1));

    always_comb begin
        tick_cnt_d = ms_tick ? '0 : tick_cnt_q + TICK_W'(1);
        lfsr_d     = lfsr_step(lfsr_q);
        // Unreachable from a non-zero seed; kept as a cheap lock-up escape.
        if (lfsr_d == 16'h0000) begin
            lfsr_d = LFSR_SEED;
        end
    end

    always_comb begin
        state_d       = state_q;
        led_d         = led_q;
        false_start_d = false_start_q;
        timeout_d     = timeout_q;
        dly_ms_d      = dly_ms_q;
        on_ms_d       = on_ms_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_FOUL, ST_TOUT: begin
                led_d = 1'b0;
                if (start_rise) begin
                    state_d       = ST_DELAY;
                    dly_ms_d      = MS_W'(MIN_DELAY_MS) + MS_W'(lfsr_q[RAND_BITS-1:0]);
                    false_start_d = 1'b0;
                    timeout_d     = 1'b0;
                end
            end
            ST_DELAY: begin
                if (btn_db) begin
                    state_d       = ST_FOUL;
                    false_start_d = 1'b1;
                end else if (ms_tick) begin
                    if (dly_ms_q == MS_W'(1)) begin
                        state_d = ST_LIT;
                        led_d   = 1'b1;
                        on_ms_d = '0;
                    end else begin
                        dly_ms_d = dly_ms_q - MS_W'(1);
                    end
                end
            end
            ST_LIT: begin
                // A press outranks a coincident timeout.
                if (btn_db) begin
                    state_d = ST_DONE;
                    led_d   = 1'b0;
                end else if (ms_tick) begin
                    if (on_ms_q == MS_W'(TIMEOUT_MS - 1)) begin
                        state_d   = ST_TOUT;
                        led_d     = 1'b0;
                        timeout_d = 1'b1;
                    end else begin
                        on_ms_d = on_ms_q + MS_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                led_d   = 1'b0;
            end
        endcase
        busy_d = (state_d == ST_DELAY) || (state_d == ST_LIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q    <= '0;
            lfsr_q        <= LFSR_SEED;
            state_q       <= ST_IDLE;
            led_q         <= 1'b0;
            false_start_q <= 1'b0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
            dly_ms_q      <= '0;
            on_ms_q       <= '0;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            lfsr_q        <= lfsr_d;
            state_q       <= state_d;
            led_q         <= led_d;
            false_start_q <= false_start_d;
            timeout_q     <= timeout_d;
            busy_q        <= busy_d;
            dly_ms_q      <= dly_ms_d;
            on_ms_q       <= on_ms_d;
        end
    end

    assign io.led         = led_q;
    assign io.btn_db      = btn_db;
    assign io.false_start = false_start_q;
    assign io.timeout     = timeout_q;
    assign io.busy        = busy_q;
    assign io.state       = state_q;

endmodule

// File: tb/tb_react_stim_ctrl.sv
// Directed bench for react_stim_ctrl with small timing parameters.
`timescale 1ns/1ps
module tb_react_stim_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    react_stim_if io ();

    react_stim_ctrl #(
        .CLK_DIV      (10),
        .MIN_DELAY_MS (5),
        .RAND_BITS    (2),
        .TIMEOUT_MS   (20),
        .DEB_MS       (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    // Reference tick phase and LFSR, both reset with the DUT.
    int          tcnt;
    logic [15:0] m_lfsr, m_lfsr_prev;

    function automatic logic [15:0] ref_next(input logic [15:0] v);
        logic [15:0] n;
        n = {1'b0, v[15:1]};
        if (v[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt        <= 0;
            m_lfsr      <= 16'hACE1;
            m_lfsr_prev <= 16'hACE1;
        end else begin
            tcnt        <= (tcnt == 9) ? 0 : tcnt + 1;
            m_lfsr_prev <= m_lfsr;
            m_lfsr      <= ref_next(m_lfsr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic get_sig(input int sel);
        case (sel)
            0:       return io.busy;
            1:       return io.led;
            2:       return io.btn_db;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic val, input int limit, inout int cnt);
        int guard = 0;
        while (get_sig(sel) !== val && guard < limit) begin
            @(negedge clk);
            cnt++;
            guard++;
        end
    endtask

    task automatic wait_phase0();
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (tcnt != 0 && guard < 20);
    endtask

    // Press start right after a tick; report cycles to busy and the LFSR in the rise cycle.
    task automatic press_start(input int hold, output int n_busy, output logic [15:0] lr);
        bit found = 0;
        n_busy = -1;
        lr = 16'h0;
        wait_phase0();
        io.start_raw = 1'b1;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (!found && io.busy === 1'b1) begin
                found  = 1;
                n_busy = i;
                lr     = m_lfsr_prev;
            end
        end
        io.start_raw = 1'b0;
    endtask

    int          n, cnt, n_exp, led_hi;
    logic [15:0] lr;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        io.start_raw = 1'b0;
        io.btn_raw   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_led",   io.led, 0);
        check("rst_state", io.state, 0);
        check("rst_busy",  io.busy, 0);
        check("rst_lfsr",  dut.lfsr_q, 16'hACE1);
        rst = 1'b0;

        // 1: idle, LFSR tracks the reference
        for (int k = 0; k < 10; k++) begin
            repeat (50) @(negedge clk);
            check("idle_lfsr", dut.lfsr_q, m_lfsr);
        end
        check("idle_led",   io.led, 0);
        check("idle_fs",    io.false_start, 0);
        check("idle_to",    io.timeout, 0);
        check("idle_busy",  io.busy, 0);
        check("idle_btndb", io.btn_db, 0);
        check("idle_state", io.state, 0);

        // 2: normal round ending in DONE
        press_start(40, n, lr);
        check("r1_busy_lat", n, 21);
        n_exp = 5 + int'(lr[1:0]);
        cnt = 40;
        wait_for(1, 1'b1, 400, cnt);
        check("r1_led_rise", cnt, 20 + 10 * n_exp);
        check("r1_state_lit", io.state, 2);
        wait_phase0();
        io.btn_raw = 1'b1;
        cnt = 0;
        wait_for(2, 1'b1, 100, cnt);
        check("r1_btndb_lat", cnt, 20);
        check("r1_led_still", io.led, 1);
        @(negedge clk);
        check("r1_done_state", io.state, 3);
        check("r1_done_led",   io.led, 0);
        check("r1_done_busy",  io.busy, 0);
        io.btn_raw = 1'b0;
        repeat (100) @(negedge clk);
        check("r1_btn_release", io.btn_db, 0);
        check("r1_done_hold",   io.state, 3);

        // 3: false start
        press_start(25, n, lr);
        check("r2_busy_lat", n, 21);
        wait_phase0();
        io.btn_raw = 1'b1;
        cnt = 0;
        wait_for(2, 1'b1, 100, cnt);
        check("r2_btndb_lat", cnt, 20);
        check("r2_led_dark", io.led, 0);
        @(negedge clk);
        check("r2_foul_state", io.state, 4);
        check("r2_foul_flag",  io.false_start, 1);
        io.btn_raw = 1'b0;
        led_hi = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (io.led !== 1'b0) led_hi++;
        end
        check("r2_led_never", led_hi, 0);
        check("r2_foul_hold", io.state, 4);
        check("r2_flag_hold", io.false_start, 1);

        // 4: new round from FOUL, then timeout
        press_start(25, n, lr);
        check("r3_busy_lat", n, 21);
        check("r3_state",    io.state, 1);
        check("r3_fs_clear", io.false_start, 0);
        n_exp = 5 + int'(lr[1:0]);
        cnt = 25;
        wait_for(1, 1'b1, 400, cnt);
        check("r3_led_rise", cnt, 20 + 10 * n_exp);
        cnt = 0;
        wait_for(1, 1'b0, 400, cnt);
        check("r3_led_on_time", cnt, 200);
        check("r3_timeout",  io.timeout, 1);
        check("r3_state",    io.state, 5);
        check("r3_busy",     io.busy, 0);

        // 5: btn glitch during LIT is filtered
        press_start(25, n, lr);
        check("r4_busy_lat",  n, 21);
        check("r4_to_clear",  io.timeout, 0);
        n_exp = 5 + int'(lr[1:0]);
        cnt = 25;
        wait_for(1, 1'b1, 400, cnt);
        check("r4_led_rise", cnt, 20 + 10 * n_exp);
        wait_phase0();
        io.btn_raw = 1'b1;
        repeat (10) @(negedge clk);
        io.btn_raw = 1'b0;
        repeat (30) @(negedge clk);
        check("r4_glitch_btndb", io.btn_db, 0);
        check("r4_glitch_state", io.state, 2);
        check("r4_glitch_led",   io.led, 1);

        // 6: async reset mid-LIT
        rst = 1'b1;
        #1;
        check("r4_rst_led",   io.led, 0);
        check("r4_rst_state", io.state, 0);
        check("r4_rst_busy",  io.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_lfsr", dut.lfsr_q, 16'hACE1);
        repeat (7) @(negedge clk);
        check("post_rst_lfsr_run", dut.lfsr_q, m_lfsr);

        // start glitch in IDLE starts nothing
        wait_phase0();
        io.start_raw = 1'b1;
        repeat (10) @(negedge clk);
        io.start_raw = 1'b0;
        repeat (100) @(negedge clk);
        check("start_glitch_busy",  io.busy, 0);
        check("start_glitch_state", io.state, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/react_stim_ctrl.md
Name: react_stim_ctrl

Overview:
- Stimulus side of the reaction-time measurement. Runs the game round and drives the LED that the reaction timer measures from.
- A debounced start press arms a round. After a pseudo-random delay the LED lights. The block then waits for the debounced reaction button, a false start, or a timeout.
- Outputs the LED and the clean button level to the timer, plus status flags to the display and top level.

Parameters:
- CLK_DIV, 50000, clk cycles per 1 ms tick (50 MHz clock).
- MIN_DELAY_MS, 1000, fixed part of the pre-stimulus delay in ms.
- RAND_BITS, 11, width of the random delay addend (0..2^RAND_BITS-1 ms).
- TIMEOUT_MS, 9999, maximum LED-on time in ms; matches the 4-digit BCD display limit.
- DEB_MS, 20, consecutive ms ticks an input must stay stable before its debounced level changes.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset: asynchronous, active-high.
- start_raw, input, 1, raw start pushbutton; not synchronised.
- btn_raw, input, 1, raw reaction pushbutton; not synchronised.
- led, output, 1, stimulus LED, 1 = lit; drives the timer's LED input.
- btn_db, output, 1, debounced reaction button level; drives the timer's btn input.
- false_start, output, 1, sticky: button pressed before the LED lit.
- timeout, output, 1, sticky: LED on for TIMEOUT_MS with no press.
- busy, output, 1, high in DELAY or LIT.
- state, output, 3, encoded FSM state, for debug and display.

Behaviour:
- Reset values: led=0, btn_db=0, false_start=0, timeout=0, busy=0, state=IDLE, tick counter=0, LFSR=16'hACE1, debouncer counters=0.
- Reset is asynchronous: asserting rst mid-round forces led low immediately.
- ms_tick:
  - Internal tick counter counts 0..CLK_DIV-1.
  - ms_tick is a 1-cycle pulse when the counter equals CLK_DIV-1; the counter then wraps to 0.
- Synchronisers: start_raw and btn_raw each pass through a 2-FF synchroniser before debouncing.
- Debouncers:
  - Output changes only after the synced input differs from the current output on DEB_MS consecutive ms_ticks.
  - Any tick where they agree clears the stability counter.
  - start_rise is a 1-cycle pulse on the 0->1 edge of the debounced start.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every clk cycle; free-running, so human timing randomises the delay.
  - Never all-zero.
- FSM states: IDLE=0, DELAY=1, LIT=2, DONE=3, FOUL=4, TOUT=5.
- IDLE -> DELAY on start_rise:
  - Load dly_ms = MIN_DELAY_MS + lfsr[RAND_BITS-1:0], using the LFSR value in that cycle.
  - Clear false_start and timeout.
- DELAY:
  - led=0; dly_ms decrements on each ms_tick.
  - btn_db==1 -> FOUL; false_start=1 from the next cycle.
  - Otherwise, ms_tick with dly_ms==1 -> LIT; led=1 from the next cycle.
  - If btn_db==1 and expiry happen in the same cycle, FOUL wins.
- LIT:
  - led=1; on_ms counts up on ms_tick, cleared on entry.
  - btn_db==1 -> DONE; led=0 from the next cycle, so the timer has already latched its count.
  - Otherwise, ms_tick with on_ms==TIMEOUT_MS-1 -> TOUT; led=0, timeout=1.
  - If a press and the timeout happen in the same cycle, DONE wins.
- DONE, FOUL, TOUT:
  - Hold the flags; led=0.
  - start_rise -> DELAY, as from IDLE: new round, flags cleared.
- start_rise while in DELAY or LIT is ignored.
- A button held across a round start lands in FOUL at the first DELAY cycle. This is intended.
- Width rules: dly_ms and on_ms are 14 bits (max value 9999 and 1000+2047). Instantiation asserts MIN_DELAY_MS + 2^RAND_BITS - 1 < 16384 and MIN_DELAY_MS >= 1.

Decomposition:
- Shared package react_pkg holds:
  - FSM state localparams (IDLE..TOUT).
  - LFSR seed 16'hACE1 and tap mask 16'hB400.
  - Default CLK_DIV.
- Sub-module debounce: a 2-FF synchroniser plus a stability counter driven by ms_tick. It is instantiated twice, for start and for btn.
- LFSR, tick generator and FSM stay in the top level.

Test Plan:
All scenarios use CLK_DIV=10, MIN_DELAY_MS=5, RAND_BITS=2, TIMEOUT_MS=20, DEB_MS=2.
1. Reset then idle 500 clk -> led=0, all flags 0, state=0; the LFSR sequence matches the reference model seeded with 16'hACE1.
2. Press start, stable 40 clk -> start_rise after 2 ticks; LED rises after exactly (5 + lfsr[1:0]@rise) ticks. Then press btn -> btn_db=1 after 2 ticks; state=3, led=0 the next cycle.
3. Press btn during DELAY -> state=4, false_start=1, led never rises. A later start press -> false_start clears, state=1.
4. Let the LED light and never press -> led falls exactly 20 ticks after rising; timeout=1, state=5.
5. Btn glitch of 1 tick during LIT -> btn_db stays 0, state stays 2. Start glitch of 1 tick in IDLE -> no round starts.
6. Assert rst during LIT -> led=0 in the same cycle, state=0. Release rst -> idle; the LFSR restarts from 16'hACE1.
